// File: rtl/lap_stopwatch.sv
// mm:ss stopwatch / countdown timer with a prescaled one-second tick and a show-ahead lap FIFO.
// Time, status and FIFO state are all registered; lap_min/lap_sec present the FIFO head.
module lap_stopwatch #(
  parameter int CLK_DIV   = 1,
  parameter int MIN_W     = 8,
  parameter int LAP_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         clear,
  input  logic                         mode_down,
  input  logic                         load,
  input  logic [MIN_W-1:0]             load_min,
  input  logic [5:0]                   load_sec,
  input  logic                         lap,
  input  logic                         lap_rd,
  output logic [MIN_W-1:0]             minutes,
  output logic [5:0]                   seconds,
  output logic [1:0]                   status,
  output logic                         expired,
  output logic                         lap_valid,
  output logic [MIN_W-1:0]             lap_min,
  output logic [5:0]                   lap_sec,
  output logic [$clog2(LAP_DEPTH):0]   lap_count,
  output logic                         lap_overflow
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int AW = $clog2(LAP_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = MIN_W + 6;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [CW-1:0] FIFO_FULL = CW'(LAP_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_EXP   = 2'b11;

  function automatic logic [5:0] sat_sec(input logic [5:0] s);
    return (s > 6'd59) ? 6'd59 : s;
  endfunction

  logic [1:0]       state_q, state_d;
  logic             mode_q, mode_d;
  logic [MIN_W-1:0] min_q, min_d;
  logic [5:0]       sec_q, sec_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             expired_q, expired_d;
  logic             tick;

  logic [EW-1:0]    mem [LAP_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             push_req, push, pop, full;

  // Timekeeping and control FSM
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    min_d     = min_q;
    sec_d     = sec_q;
    presc_d   = presc_q;
    expired_d = 1'b0;
    tick      = (state_q == S_RUN) && (presc_q == PRESC_MAX);

    if (state_q == S_RUN) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end

    if (tick) begin
      if (!mode_q) begin
        if (sec_q == 6'd59) begin
          sec_d = 6'd0;
          min_d = min_q + MIN_W'(1);
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        if (sec_q == 6'd0) begin
          sec_d = 6'd59;
          min_d = min_q - MIN_W'(1);
        end else begin
          sec_d = sec_q - 6'd1;
        end
        if ((min_d == '0) && (sec_d == 6'd0)) begin
          state_d   = S_EXP;
          expired_d = 1'b1;
        end
      end
    end

    // Commands are mutually exclusive by priority; the running count above still applies.
    if (clear) begin
      state_d   = S_IDLE;
      min_d     = '0;
      sec_d     = 6'd0;
      presc_d   = '0;
      expired_d = 1'b0;
    end else if (load) begin
      if ((state_q == S_IDLE) || (state_q == S_PAUSE)) begin
        min_d   = load_min;
        sec_d   = sat_sec(load_sec);
        presc_d = '0;
      end
    end else if (stop) begin
      if ((state_q == S_RUN) && !expired_d) begin
        state_d = S_PAUSE;
      end
    end else if (start) begin
      if (state_q == S_IDLE) begin
        if (!(mode_down && (min_q == '0) && (sec_q == 6'd0))) begin
          state_d = S_RUN;
          mode_d  = mode_down;
          presc_d = '0;
        end
      end else if (state_q == S_PAUSE) begin
        state_d = S_RUN;
      end
    end
  end

  // Lap FIFO bookkeeping
  always_comb begin
    full     = (cnt_q == FIFO_FULL);
    push_req = lap && ((state_q == S_RUN) || (state_q == S_PAUSE)) && !clear;
    pop      = lap_rd && (cnt_q != '0) && !clear;
    push     = push_req && (!full || pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q || (push_req && full && !pop);

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CW'(1);
    end

    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      min_q     <= '0;
      sec_q     <= 6'd0;
      presc_q   <= '0;
      expired_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      presc_q   <= presc_d;
      expired_q <= expired_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  // Captures the time as displayed this cycle, i.e. before any coincident tick.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr_q] <= {min_q, sec_q};
    end
  end

  assign minutes      = min_q;
  assign seconds      = sec_q;
  assign status       = state_q;
  assign expired      = expired_q;
  assign lap_valid    = (cnt_q != '0);
  assign lap_min      = lap_valid ? mem[rd_ptr_q][EW-1:6] : '0;
  assign lap_sec      = lap_valid ? mem[rd_ptr_q][5:0] : 6'd0;
  assign lap_count    = cnt_q;
  assign lap_overflow = ovf_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Scoreboard bench for lap_stopwatch: a CLK_DIV=1 instance and a CLK_DIV=4 instance share stimulus.
// Stimulus queues expected snapshots and lap entries; the negedge monitor pops and compares them.
module tb_lap_stopwatch;

  logic       clk = 1'b0;
  logic       rst, start, stop, clear, mode_down, load, lap, lap_rd;
  logic [7:0] load_min;
  logic [5:0] load_sec;

  logic [7:0] minutes, minutes4, lap_min, lap_min4;
  logic [5:0] seconds, seconds4, lap_sec, lap_sec4;
  logic [1:0] status, status4;
  logic       expired, expired4, lap_valid, lap_valid4, lap_overflow, lap_overflow4;
  logic [2:0] lap_count, lap_count4;

  int nchk = 0;
  int nerr = 0;
  int exp_pend = 0;

  string e_name[$];
  int    e_min[$], e_sec[$], e_st[$], e_cnt[$], e_ovf[$], e_vld[$], e_ex[$];
  bit    e_d4[$];
  int    l_min[$], l_sec[$];

  always #5 clk = ~clk;

  lap_stopwatch #(.CLK_DIV(1), .MIN_W(8), .LAP_DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .mode_down(mode_down), .load(load), .load_min(load_min), .load_sec(load_sec),
    .lap(lap), .lap_rd(lap_rd), .minutes(minutes), .seconds(seconds), .status(status),
    .expired(expired), .lap_valid(lap_valid), .lap_min(lap_min), .lap_sec(lap_sec),
    .lap_count(lap_count), .lap_overflow(lap_overflow)
  );

  lap_stopwatch #(.CLK_DIV(4), .MIN_W(8), .LAP_DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .mode_down(mode_down), .load(load), .load_min(load_min), .load_sec(load_sec),
    .lap(lap), .lap_rd(lap_rd), .minutes(minutes4), .seconds(seconds4), .status(status4),
    .expired(expired4), .lap_valid(lap_valid4), .lap_min(lap_min4), .lap_sec(lap_sec4),
    .lap_count(lap_count4), .lap_overflow(lap_overflow4)
  );

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Fields left at -1 are not compared.
  task automatic expect_t(input string nm, input int mn, input int sc, input int st,
                          input int cnt = -1, input int ovf = -1, input int vld = -1,
                          input int ex = -1, input bit d4 = 1'b0);
    e_name.push_back(nm);
    e_min.push_back(mn);
    e_sec.push_back(sc);
    e_st.push_back(st);
    e_cnt.push_back(cnt);
    e_ovf.push_back(ovf);
    e_vld.push_back(vld);
    e_ex.push_back(ex);
    e_d4.push_back(d4);
  endtask

  task automatic exp_lap(input int mn, input int sc);
    l_min.push_back(mn);
    l_sec.push_back(sc);
  endtask

  task automatic do_start();
    start = 1'b1; cyc(1); start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1; cyc(1); stop = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; cyc(1); clear = 1'b0;
  endtask

  task automatic do_load(input int mn, input int sc);
    load_min = 8'(mn);
    load_sec = 6'(sc);
    load = 1'b1; cyc(1); load = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    string nm;
    int    mn, sc, st, cn, ov, vd, ex;
    bit    d4;
    while (e_name.size() > 0) begin
      nm = e_name.pop_front();
      mn = e_min.pop_front();
      sc = e_sec.pop_front();
      st = e_st.pop_front();
      cn = e_cnt.pop_front();
      ov = e_ovf.pop_front();
      vd = e_vld.pop_front();
      ex = e_ex.pop_front();
      d4 = e_d4.pop_front();
      if (mn >= 0) chk({nm, ".min"}, d4 ? int'(minutes4) : int'(minutes), mn);
      if (sc >= 0) chk({nm, ".sec"}, d4 ? int'(seconds4) : int'(seconds), sc);
      if (st >= 0) chk({nm, ".status"}, d4 ? int'(status4) : int'(status), st);
      if (cn >= 0) chk({nm, ".lap_count"}, d4 ? int'(lap_count4) : int'(lap_count), cn);
      if (ov >= 0) chk({nm, ".lap_overflow"}, d4 ? int'(lap_overflow4) : int'(lap_overflow), ov);
      if (vd >= 0) chk({nm, ".lap_valid"}, d4 ? int'(lap_valid4) : int'(lap_valid), vd);
      if (ex >= 0) chk({nm, ".expired"}, d4 ? int'(expired4) : int'(expired), ex);
    end
    if (lap_rd && lap_valid) begin
      if (l_min.size() == 0) begin
        chk("lap_unexpected_valid", int'(lap_valid), 0);
      end else begin
        mn = l_min.pop_front();
        sc = l_sec.pop_front();
        chk("lap_head_min", int'(lap_min), mn);
        chk("lap_head_sec", int'(lap_sec), sc);
      end
    end
    if (expired) begin
      if (exp_pend > 0) exp_pend--;
      else chk("expired_unexpected", int'(expired), 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; mode_down = 1'b0;
    load = 1'b0; lap = 1'b0; lap_rd = 1'b0; load_min = 8'd0; load_sec = 6'd0;
    cyc(2);
    rst = 1'b0;
    expect_t("reset", 0, 0, 0, 0, 0, 0, 0);
    expect_t("reset4", 0, 0, 0, 0, 0, 0, 0, 1'b1);

    // Basic up count; the stop edge is still a running cycle and ticks once more
    do_start();
    expect_t("t1_start", 0, 0, 1);
    cyc(124);
    expect_t("t1_2m04", 2, 4, 1);
    do_stop();
    expect_t("t1_stop", 2, 5, 2);
    cyc(5);
    expect_t("t1_frozen", 2, 5, 2);

    // Up count wrap at 255:59
    do_clear();
    expect_t("t2_clear", 0, 0, 0, 0, 0, 0);
    do_load(255, 58);
    expect_t("t2_load", 255, 58, 0);
    do_start();
    expect_t("t2_start", 255, 58, 1);
    cyc(1);
    expect_t("t2_tick1", 255, 59, 1);
    cyc(1);
    expect_t("t2_wrap", 0, 0, 1);
    cyc(1);
    expect_t("t2_after_wrap", 0, 1, 1);

    // Countdown to expiry
    do_clear();
    mode_down = 1'b1;
    do_load(1, 2);
    do_start();
    mode_down = 1'b0;
    expect_t("t3_start", 1, 2, 1);
    cyc(1);
    expect_t("t3_1m01", 1, 1, 1);
    cyc(1);
    expect_t("t3_1m00", 1, 0, 1);
    cyc(1);
    expect_t("t3_0m59", 0, 59, 1, -1, -1, -1, 0);
    cyc(58);
    expect_t("t3_0m01", 0, 1, 1, -1, -1, -1, 0);
    exp_pend = 1;
    cyc(1);
    expect_t("t3_expire", 0, 0, 3, -1, -1, -1, 1);
    cyc(1);
    expect_t("t3_pulse_end", 0, 0, 3, -1, -1, -1, 0);
    do_start();
    expect_t("t3_start_ignored", 0, 0, 3);
    do_clear();
    expect_t("t3_clear", 0, 0, 0, -1, -1, -1, 0);

    // Lap FIFO fill, overflow and ordered drain
    do_clear();
    do_start();
    lap = 1'b1;
    exp_lap(0, 0); exp_lap(0, 1); exp_lap(0, 2); exp_lap(0, 3);
    cyc(5);
    lap = 1'b0;
    expect_t("t4_full", 0, 5, 1, 4, 1, 1);
    do_stop();
    expect_t("t4_stop", 0, 6, 2, 4, 1, 1);
    lap_rd = 1'b1; cyc(4); lap_rd = 1'b0;
    expect_t("t4_drained", 0, 6, 2, 0, 1, 0);
    lap_rd = 1'b1; cyc(1); lap_rd = 1'b0;
    expect_t("t4_rd_empty", 0, 6, 2, 0, 1, 0);
    do_clear();
    expect_t("t4_clear", 0, 0, 0, 0, 0, 0);
    lap = 1'b1; cyc(1); lap = 1'b0;
    expect_t("t4_lap_idle", 0, 0, 0, 0, 0, 0);
    do_start();
    do_stop();
    expect_t("t4_paused", 0, 1, 2, 0, 0, 0);
    exp_lap(0, 1);
    lap = 1'b1; cyc(1); lap = 1'b0;
    do_load(0, 7);
    exp_lap(0, 7); exp_lap(0, 7); exp_lap(0, 7);
    lap = 1'b1; cyc(3); lap = 1'b0;
    expect_t("t4_full2", 0, 7, 2, 4, 0, 1);
    exp_lap(0, 7);
    lap = 1'b1; lap_rd = 1'b1; cyc(1); lap = 1'b0; lap_rd = 1'b0;
    expect_t("t4_full_pushpop", 0, 7, 2, 4, 0, 1);
    lap_rd = 1'b1; cyc(4); lap_rd = 1'b0;
    expect_t("t4_drained2", 0, 7, 2, 0, 0, 0);
    exp_lap(0, 7);
    lap = 1'b1; lap_rd = 1'b1; cyc(1); lap = 1'b0; lap_rd = 1'b0;
    expect_t("t4_empty_pushpop", 0, 7, 2, 1, 0, 1);
    lap_rd = 1'b1; cyc(1); lap_rd = 1'b0;
    expect_t("t4_last_pop", 0, 7, 2, 0, 0, 0);

    // CLK_DIV=4: partial second survives pause, then reset mid-run
    rst = 1'b1; cyc(1); rst = 1'b0;
    do_start();
    cyc(5);
    do_stop();
    expect_t("t5_stop", 0, 1, 2, -1, -1, -1, -1, 1'b1);
    cyc(3);
    expect_t("t5_hold", 0, 1, 2, -1, -1, -1, -1, 1'b1);
    do_start();
    expect_t("t5_resume", 0, 1, 1, -1, -1, -1, -1, 1'b1);
    cyc(1);
    expect_t("t5_resume_1", 0, 1, 1, -1, -1, -1, -1, 1'b1);
    cyc(1);
    expect_t("t5_resume_2", 0, 2, 1, -1, -1, -1, -1, 1'b1);
    cyc(4);
    expect_t("t5_next_sec", 0, 3, 1, -1, -1, -1, -1, 1'b1);
    rst = 1'b1; cyc(1); rst = 1'b0;
    expect_t("t5_rst4", 0, 0, 0, 0, 0, 0, 0, 1'b1);
    expect_t("t5_rst", 0, 0, 0, 0, 0, 0, 0);

    // Priority and ignored-command cases
    do_start();
    do_stop();
    expect_t("t6_paused", 0, 1, 2);
    start = 1'b1; stop = 1'b1; cyc(1); start = 1'b0; stop = 1'b0;
    expect_t("t6_start_stop", 0, 1, 2);
    do_start();
    expect_t("t6_resume", 0, 1, 1);
    do_load(5, 5);
    expect_t("t6_load_running", 0, 2, 1);
    do_clear();
    do_load(3, 63);
    expect_t("t6_sec_saturate", 3, 59, 0);
    do_clear();
    mode_down = 1'b1;
    do_start();
    mode_down = 1'b0;
    expect_t("t6_down_zero", 0, 0, 0);

    cyc(2);
    chk("lap_queue_empty", l_min.size(), 0);
    chk("expired_pending", exp_pend, 0);
    chk("expect_queue_empty", e_name.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
